// File: rtl/riscpu_pkg.sv
// rtl/riscpu_pkg.sv - shared opcodes and widths for the RISC pipeline
//
// Purpose: opcode encodings and data/address widths used by the writeback
// stage and its source mux. No ports.
package riscpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_MOV = 6'h01;
  localparam logic [5:0] OP_LI  = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;

endpackage

// File: rtl/wb_select.sv
// rtl/wb_select.sv - opcode-driven writeback source mux
//
// Purpose: picks the value the WB stage commits to the register file.
// Ports:
//   opcode     in   6     instruction opcode
//   reg_rs1    in   XLEN  rs1 operand (MOV source)
//   alu_out    in   XLEN  ALU result (default source)
//   imm        in   XLEN  decoded immediate (LI source)
//   dout       in   XLEN  data-memory read data (LW source)
//   wb_data    out  XLEN  selected writeback value
module wb_select
  import riscpu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [5:0]   opcode,
  input  logic [W-1:0] reg_rs1,
  input  logic [W-1:0] alu_out,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] dout,
  output logic [W-1:0] wb_data
);

  always_comb begin
    wb_data = alu_out;
    case (opcode)
      OP_LW:   wb_data = dout;
      OP_LI:   wb_data = imm;
      OP_MOV:  wb_data = reg_rs1;
      default: wb_data = alu_out;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - WB stage: source select, register file, forward tap, commit counter
//
// Purpose: final pipeline stage. Selects the writeback value by opcode,
// commits it to a 32x32 register file (x0 hardwired to zero), serves two
// combinational decode read ports, exports a registered forward tap of the
// last committed write and counts committed writes.
// Configuration: define WB_BYPASS_EN to make a same-cycle write visible on
// the read ports (write-through); otherwise reads return the pre-write value.
// Ports:
//   clock               in   1      rising-edge clock
//   reset_n             in   1      asynchronous active-low reset
//   reg_rs1_d3          in   XLEN   rs1 operand carried to WB
//   alu_out_d3          in   XLEN   ALU result
//   immediate_value_d3  in   XLEN   decoded immediate
//   DOut_d3             in   XLEN   data-memory read data
//   opcode_d3           in   6      instruction opcode
//   rd_d3               in   5      destination register
//   register_we_d3      in   1      register write request
//   rs1_addr, rs2_addr  in   5      decode read addresses
//   rs1_data, rs2_data  out  XLEN   decode read data (combinational)
//   wb_data             out  XLEN   selected writeback value (combinational)
//   wb_fwd_data         out  XLEN   wb_data of last committed write (held)
//   wb_fwd_rd           out  5      rd of last-cycle commit, 0 when none
//   wb_fwd_valid        out  1      a write committed last cycle
//   commit_count        out  CNT_W  number of committed writes (wraps)
module writeback_regfile
  import riscpu_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [XLEN_P-1:0] reg_rs1_d3,
  input  logic [XLEN_P-1:0] alu_out_d3,
  input  logic [XLEN_P-1:0] immediate_value_d3,
  input  logic [XLEN_P-1:0] DOut_d3,
  input  logic [5:0]        opcode_d3,
  input  logic [REG_AW-1:0] rd_d3,
  input  logic              register_we_d3,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN_P-1:0] rs1_data,
  output logic [XLEN_P-1:0] rs2_data,
  output logic [XLEN_P-1:0] wb_data,
  output logic [XLEN_P-1:0] wb_fwd_data,
  output logic [REG_AW-1:0] wb_fwd_rd,
  output logic              wb_fwd_valid,
  output logic [CNT_W-1:0]  commit_count
);

  logic [XLEN_P-1:0] regs [NREGS];
  logic              commit;

  wb_select #(.W(XLEN_P)) u_wb_select (
    .opcode  (opcode_d3),
    .reg_rs1 (reg_rs1_d3),
    .alu_out (alu_out_d3),
    .imm     (immediate_value_d3),
    .dout    (DOut_d3),
    .wb_data (wb_data)
  );

  // Writes to x0 are discarded entirely: no array update, no count, no forward.
  assign commit = register_we_d3 && (rd_d3 != '0);

  // regs[0] is reset and never written, so it stays a constant zero; the read
  // mux still forces zero for address 0 so that intent is explicit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[rd_d3] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) rs1_data = regs[rs1_addr];
    if (rs2_addr != '0) rs2_data = regs[rs2_addr];
`ifdef WB_BYPASS_EN
    // Write-through: a read of the register being committed this cycle sees
    // the new value instead of the array contents.
    if (commit && (rs1_addr == rd_d3)) rs1_data = wb_data;
    if (commit && (rs2_addr == rd_d3)) rs2_data = wb_data;
`endif
  end

  // Forward tap: valid/rd describe only the previous cycle, data is held
  // from the most recent commit so a late consumer still sees it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_fwd_valid <= 1'b0;
      wb_fwd_rd    <= '0;
      wb_fwd_data  <= '0;
    end else begin
      wb_fwd_valid <= commit;
      wb_fwd_rd    <= commit ? rd_d3 : '0;
      if (commit) wb_fwd_data <= wb_data;
    end
  end

  // Free-running wrap-around commit counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_count <= '0;
    end else if (commit) begin
      commit_count <= commit_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile
module tb_writeback_regfile;

  localparam int CW = 4;

  logic        clock;
  logic        reset_n;
  logic [31:0] reg_rs1_d3, alu_out_d3, immediate_value_d3, DOut_d3;
  logic [5:0]  opcode_d3;
  logic [4:0]  rd_d3;
  logic        register_we_d3;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data, wb_fwd_data;
  logic [4:0]  wb_fwd_rd;
  logic        wb_fwd_valid;
  logic [CW-1:0] commit_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_cnt;

  writeback_regfile #(.CNT_W(CW)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .reg_rs1_d3         (reg_rs1_d3),
    .alu_out_d3         (alu_out_d3),
    .immediate_value_d3 (immediate_value_d3),
    .DOut_d3            (DOut_d3),
    .opcode_d3          (opcode_d3),
    .rd_d3              (rd_d3),
    .register_we_d3     (register_we_d3),
    .rs1_addr           (rs1_addr),
    .rs2_addr           (rs2_addr),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .wb_data            (wb_data),
    .wb_fwd_data        (wb_fwd_data),
    .wb_fwd_rd          (wb_fwd_rd),
    .wb_fwd_valid       (wb_fwd_valid),
    .commit_count       (commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs1v;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] dout;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    register_we_d3     = 1'b0;
    opcode_d3          = 6'h00;
    rd_d3              = 5'd0;
    reg_rs1_d3         = '0;
    alu_out_d3         = '0;
    immediate_value_d3 = '0;
    DOut_d3            = '0;
  endtask

  // Drive a write at the negedge; it commits at the following posedge.
  task automatic drive_write(input logic [5:0] op, input logic [31:0] rs1v,
                             input logic [31:0] alu, input logic [31:0] imm,
                             input logic [31:0] dout, input logic [4:0] rd);
    opcode_d3          = op;
    reg_rs1_d3         = rs1v;
    alu_out_d3         = alu;
    immediate_value_d3 = imm;
    DOut_d3            = dout;
    rd_d3              = rd;
    register_we_d3     = 1'b1;
  endtask

  initial begin
    vecs[0] = '{6'h23, 32'h0,    32'h1,    32'h2,    32'hDEADBEEF, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{6'h0F, 32'h0,    32'h3,    32'h1234, 32'h4,        5'd5,  32'h1234};
    vecs[2] = '{6'h10, 32'h8,    32'h7,    32'h9,    32'hA,        5'd5,  32'h7};
    vecs[3] = '{6'h01, 32'hA5A5, 32'hB,    32'hC,    32'hD,        5'd6,  32'hA5A5};
    vecs[4] = '{6'h00, 32'h1,    32'h55,   32'h2,    32'h3,        5'd31, 32'h55};

    idle();
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    reset_n  = 1'b0;
    exp_cnt  = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Post-reset state
    rs1_addr = 5'd1; rs2_addr = 5'd31;
    #1;
    check("reset_rs1", rs1_data, 32'h0);
    check("reset_rs2", rs2_data, 32'h0);
    check("reset_count", {28'h0, commit_count}, 32'h0);
    check("reset_fwd_valid", {31'h0, wb_fwd_valid}, 32'h0);

    // Source mux table
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      drive_write(vecs[i].op, vecs[i].rs1v, vecs[i].alu, vecs[i].imm, vecs[i].dout, vecs[i].rd);
      #1;
      check($sformatf("wb_data[%0d]", i), wb_data, vecs[i].exp);
      @(negedge clock);
      idle();
      exp_cnt = exp_cnt + 1'b1;
      rs1_addr = vecs[i].rd;
      rs2_addr = vecs[i].rd;
      #1;
      check($sformatf("reg_rs1[%0d]", i), rs1_data, vecs[i].exp);
      check($sformatf("reg_rs2[%0d]", i), rs2_data, vecs[i].exp);
      check($sformatf("count[%0d]", i), {28'h0, commit_count}, {28'h0, exp_cnt});
    end

    // x0 write is discarded
    @(negedge clock);
    drive_write(6'h10, 32'h0, 32'hFFFF, 32'h0, 32'h0, 5'd0);
    @(negedge clock);
    idle();
    rs1_addr = 5'd0;
    #1;
    check("x0_read", rs1_data, 32'h0);
    check("x0_count", {28'h0, commit_count}, {28'h0, exp_cnt});
    check("x0_fwd_valid", {31'h0, wb_fwd_valid}, 32'h0);
    check("x0_fwd_rd", {27'h0, wb_fwd_rd}, 32'h0);

    // Same-cycle write/read of r3
    @(negedge clock);
    drive_write(6'h10, 32'h0, 32'h2, 32'h0, 32'h0, 5'd3);
    @(negedge clock);
    exp_cnt = exp_cnt + 1'b1;
    drive_write(6'h01, 32'h9, 32'h0, 32'h0, 32'h0, 5'd3);
    rs1_addr = 5'd3;
    #1;
`ifdef WB_BYPASS_EN
    check("same_cycle_rs1", rs1_data, 32'h9);
`else
    check("same_cycle_rs1", rs1_data, 32'h2);
`endif
    @(negedge clock);
    idle();
    exp_cnt = exp_cnt + 1'b1;
    #1;
    check("next_cycle_rs1", rs1_data, 32'h9);

    // Forward tap
    @(negedge clock);
    drive_write(6'h10, 32'h0, 32'd42, 32'h0, 32'h0, 5'd7);
    @(negedge clock);
    idle();
    exp_cnt = exp_cnt + 1'b1;
    #1;
    check("fwd_valid", {31'h0, wb_fwd_valid}, 32'h1);
    check("fwd_rd", {27'h0, wb_fwd_rd}, 32'd7);
    check("fwd_data", wb_fwd_data, 32'd42);
    @(negedge clock);
    #1;
    check("fwd_idle_valid", {31'h0, wb_fwd_valid}, 32'h0);
    check("fwd_idle_rd", {27'h0, wb_fwd_rd}, 32'h0);
    check("fwd_idle_data_hold", wb_fwd_data, 32'd42);
    check("count_before_reset", {28'h0, commit_count}, {28'h0, exp_cnt});

    // Mid-run asynchronous reset with a write pending: the write is dropped
    @(negedge clock);
    drive_write(6'h10, 32'h0, 32'h77, 32'h0, 32'h0, 5'd9);
    #2;
    reset_n = 1'b0;
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    #1;
    check("midreset_rs1", rs1_data, 32'h0);
    check("midreset_rs2", rs2_data, 32'h0);
    check("midreset_count", {28'h0, commit_count}, 32'h0);
    check("midreset_fwd_valid", {31'h0, wb_fwd_valid}, 32'h0);
    @(negedge clock);
    rs1_addr = 5'd9;
    #1;
    check("midreset_dropped", rs1_data, 32'h0);
    exp_cnt = '0;

    // First commit right after reset release
    @(negedge clock);
    drive_write(6'h10, 32'h0, 32'h44, 32'h0, 32'h0, 5'd4);
    reset_n = 1'b1;
    @(negedge clock);
    idle();
    exp_cnt = exp_cnt + 1'b1;
    rs1_addr = 5'd4;
    #1;
    check("first_commit", rs1_data, 32'h44);

    // Counter wrap: reach 15, then one more wraps to 0
    for (int i = 1; i < 15; i++) begin
      @(negedge clock);
      drive_write(6'h10, 32'h0, 32'(i), 32'h0, 32'h0, 5'd10);
    end
    @(negedge clock);
    idle();
    exp_cnt = 4'd15;
    #1;
    check("count_15", {28'h0, commit_count}, 32'd15);
    @(negedge clock);
    drive_write(6'h10, 32'h0, 32'h1, 32'h0, 32'h0, 5'd10);
    @(negedge clock);
    idle();
    #1;
    check("count_wrap", {28'h0, commit_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
